ncl_add_pipe: RTL and testbench

NCL_ADD_PIPE -- requirements
Module: ncl_add_pipe

---
 rtl/ncl_pkg.sv | 69 ++++++
 rtl/ncl_add_stage.sv | 118 +++++++++++
 rtl/ncl_add_pipe.sv | 78 +++++++
 tb/tb_ncl_add_pipe.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Dual-rail (NCL) encoding constants and wavefront helpers shared by the adder pipeline.
package ncl_pkg;

   typedef logic [1:0] dr_t;

   localparam dr_t NULL = 2'b00;
   localparam dr_t D0   = 2'b01;
   localparam dr_t D1   = 2'b10;
   localparam dr_t ILL  = 2'b11;

   // Wavefront helpers take up to MAX_PAIRS rail pairs; callers zero-extend and pass a pair mask.
   localparam int unsigned MAX_PAIRS = 64;
   typedef logic [2*MAX_PAIRS-1:0] wave_t;
   typedef logic [MAX_PAIRS-1:0]   pmask_t;

   typedef struct packed {
      dr_t c;
      dr_t s;
   } fa_t;

   function automatic logic is_data(input dr_t p);
      return (p == D0) || (p == D1);
   endfunction

   // 1 when every selected pair carries DATA (an empty selection counts as complete).
   function automatic logic wave_data(input wave_t w, input pmask_t m);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
         if (m[i] && !is_data(w[2*i +: 2])) ok = 1'b0;
      end
      return ok;
   endfunction

   // 1 when every selected pair is NULL.
   function automatic logic wave_null(input wave_t w, input pmask_t m);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
         if (m[i] && (w[2*i +: 2] != NULL)) ok = 1'b0;
      end
      return ok;
   endfunction

   // 1 when any selected pair holds the illegal 11 code.
   function automatic logic wave_ill(input wave_t w, input pmask_t m);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < MAX_PAIRS; i++) begin
         if (m[i] && (w[2*i +: 2] == ILL)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Dual-rail full add; output stays NULL until all three inputs are DATA.
   function automatic fa_t dr_full_add(input dr_t a, input dr_t b, input dr_t c);
      fa_t        r;
      logic [1:0] v;
      r.s = NULL;
      r.c = NULL;
      if (is_data(a) && is_data(b) && is_data(c)) begin
         v   = {1'b0, a[1]} + {1'b0, b[1]} + {1'b0, c[1]};
         r.s = v[0] ? D1 : D0;
         r.c = v[1] ? D1 : D0;
      end
      return r;
   endfunction

endpackage

// File: rtl/ncl_add_stage.sv
// One pipeline stage: adds digit K with the incoming carry and captures with TH22 hysteresis.
module ncl_add_stage
   import ncl_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2,
   parameter int unsigned K     = 0
) (
   input  logic               clk_i,
   input  logic               init_i,
   input  logic [2*WIDTH-1:0] a_i,
   input  logic [2*WIDTH-1:0] b_i,
   input  logic [2*WIDTH-1:0] s_i,
   input  logic [1:0]         c_i,
   input  logic               succ_comp_i,
   output logic [2*WIDTH-1:0] a_o,
   output logic [2*WIDTH-1:0] b_o,
   output logic [2*WIDTH-1:0] s_o,
   output logic [1:0]         c_o,
   output logic               comp_o
);

   localparam int unsigned Lo = K * DIGIT;        // first bit of this stage's digit
   localparam int unsigned Hi = (K + 1) * DIGIT;  // first bit past it

   function automatic logic [WIDTH-1:0] bits_from(input int unsigned lsb);
      logic [WIDTH-1:0] m;
      for (int unsigned i = 0; i < WIDTH; i++) m[i] = (i >= lsb);
      return m;
   endfunction

   function automatic logic [2*WIDTH-1:0] rails(input logic [WIDTH-1:0] m);
      logic [2*WIDTH-1:0] r;
      for (int unsigned i = 0; i < WIDTH; i++) r[2*i +: 2] = {2{m[i]}};
      return r;
   endfunction

   // Meaningful fields: operands still to be added, and sum digits already produced.
   localparam logic [WIDTH-1:0] InOpMask   = bits_from(Lo);
   localparam logic [WIDTH-1:0] InSumMask  = ~InOpMask;
   localparam logic [WIDTH-1:0] RegOpMask  = bits_from(Hi);
   localparam logic [WIDTH-1:0] RegSumMask = ~RegOpMask;

   logic [2*WIDTH-1:0] a_d, a_q, b_d, b_q, s_d, s_q;
   logic [1:0]         c_d, c_q;
   logic [2*WIDTH-1:0] sum_w;
   logic [1:0]         carry_w;
   fa_t                fa_w;
   logic               in_data_w, in_null_w, capture_w;

   // Ripple this stage's digit through dual-rail full adders.
   always_comb begin
      sum_w   = s_i & rails(InSumMask);
      carry_w = c_i;
      fa_w    = '0;
      for (int unsigned j = 0; j < DIGIT; j++) begin
         fa_w                  = dr_full_add(a_i[2*(Lo+j) +: 2], b_i[2*(Lo+j) +: 2], carry_w);
         sum_w[2*(Lo+j) +: 2]  = fa_w.s;
         carry_w               = fa_w.c;
      end
   end

   // Classify the incoming wavefront and apply the TH22 capture rule.
   always_comb begin
      in_data_w = wave_data(wave_t'(a_i), pmask_t'(InOpMask))
                  && wave_data(wave_t'(b_i), pmask_t'(InOpMask))
                  && wave_data(wave_t'(s_i), pmask_t'(InSumMask))
                  && is_data(c_i);
      in_null_w = wave_null(wave_t'(a_i), pmask_t'(InOpMask))
                  && wave_null(wave_t'(b_i), pmask_t'(InOpMask))
                  && wave_null(wave_t'(s_i), pmask_t'(InSumMask))
                  && (c_i == NULL);
      capture_w = (in_data_w && !succ_comp_i) || (in_null_w && succ_comp_i);
   end

   // Next register contents: new wavefront on capture, otherwise hold.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      s_d = s_q;
      c_d = c_q;
      if (capture_w) begin
         a_d = a_i & rails(RegOpMask);
         b_d = b_i & rails(RegOpMask);
         s_d = sum_w;
         c_d = carry_w;
      end
   end

   // Stage register, cleared to NULL by init.
   always_ff @(posedge clk_i or posedge init_i) begin
      if (init_i) begin
         a_q <= '0;
         b_q <= '0;
         s_q <= '0;
         c_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         s_q <= s_d;
         c_q <= c_d;
      end
   end

   // Completion: register holds complete DATA across its meaningful fields.
   always_comb begin
      comp_o = wave_data(wave_t'(a_q), pmask_t'(RegOpMask))
               && wave_data(wave_t'(b_q), pmask_t'(RegOpMask))
               && wave_data(wave_t'(s_q), pmask_t'(RegSumMask))
               && is_data(c_q);
   end

   assign a_o = a_q;
   assign b_o = b_q;
   assign s_o = s_q;
   assign c_o = c_q;

endmodule

// File: rtl/ncl_add_pipe.sv
// Digit-serial dual-rail adder pipeline (WIDTH <= 64) with a sticky illegal-encoding flag.
module ncl_add_pipe
   import ncl_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic               clk,
   input  logic               init,
   input  logic [2*WIDTH-1:0] a,
   input  logic [2*WIDTH-1:0] b,
   input  logic [1:0]         cin,
   output logic               in_comp,
   output logic [2*WIDTH-1:0] sum,
   output logic [1:0]         cout,
   input  logic               out_comp,
   output logic               err
);

   localparam int unsigned STAGES = WIDTH / DIGIT;

   // Index k is the input of stage k; index STAGES is the last stage's register.
   logic [2*WIDTH-1:0] a_w [STAGES+1];
   logic [2*WIDTH-1:0] b_w [STAGES+1];
   logic [2*WIDTH-1:0] s_w [STAGES+1];
   logic [1:0]         c_w [STAGES+1];
   // comp_w[k] is stage k's completion; comp_w[STAGES] is the downstream one.
   logic               comp_w [STAGES+1];

   logic err_d, err_q, ill_w;

   assign a_w[0]         = a;
   assign b_w[0]         = b;
   assign s_w[0]         = '0;
   assign c_w[0]         = cin;
   assign comp_w[STAGES] = out_comp;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      ncl_add_stage #(
         .WIDTH(WIDTH),
         .DIGIT(DIGIT),
         .K    (k)
      ) u_stage (
         .clk_i      (clk),
         .init_i     (init),
         .a_i        (a_w[k]),
         .b_i        (b_w[k]),
         .s_i        (s_w[k]),
         .c_i        (c_w[k]),
         .succ_comp_i(comp_w[k+1]),
         .a_o        (a_w[k+1]),
         .b_o        (b_w[k+1]),
         .s_o        (s_w[k+1]),
         .c_o        (c_w[k+1]),
         .comp_o     (comp_w[k])
      );
   end

   // Any 11 pair on the primary inputs sets the sticky error.
   always_comb begin
      ill_w = wave_ill(wave_t'(a), pmask_t'({WIDTH{1'b1}}))
              || wave_ill(wave_t'(b), pmask_t'({WIDTH{1'b1}}))
              || (cin == ILL);
      err_d = err_q || ill_w;
   end

   // Error flag register; only init clears it.
   always_ff @(posedge clk or posedge init) begin
      if (init) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign in_comp = comp_w[0];
   assign sum     = s_w[STAGES];
   assign cout    = c_w[STAGES];
   assign err     = err_q;

endmodule

// File: tb/tb_ncl_add_pipe.sv
// Bench for ncl_add_pipe: token-level model checked every cycle, plus directed literal checks.
module tb_ncl_add_pipe;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DIGIT  = 2;
   localparam int          STAGES = 4;

   logic        clk = 1'b0;
   logic        init;
   logic [15:0] a, b, sum;
   logic [1:0]  cin, cout;
   logic        in_comp, out_comp, err;

   int total = 0;
   int bad   = 0;

   ncl_add_pipe #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk     (clk),
      .init    (init),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .in_comp (in_comp),
      .sum     (sum),
      .cout    (cout),
      .out_comp(out_comp),
      .err     (err)
   );

   always #5 clk = ~clk;

   // Model: each stage holds NULL or one token {a, b, cin}.
   bit          mk [STAGES];
   logic [16:0] mv [STAGES];
   bit          merr;

   // Environment: handshaking source and sink.
   logic [16:0] src_q [$];
   logic [8:0]  exp_q [$];
   logic [16:0] src_tok;
   bit          src_en, snk_en, snk_hold, snk_rand;
   int          src_ph, acc_cnt, rx_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc8(input logic [7:0] v);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   function automatic logic [7:0] dec8(input logic [15:0] r);
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = r[2*i+1];
      return v;
   endfunction

   // 0 = all NULL, 1 = all DATA, 2 = anything else.
   function automatic int classify(input logic [33:0] w, input int n);
      int nd, nn;
      nd = 0;
      nn = 0;
      for (int i = 0; i < n; i++) begin
         if (w[2*i +: 2] == 2'b01 || w[2*i +: 2] == 2'b10) nd++;
         else if (w[2*i +: 2] == 2'b00) nn++;
      end
      if (nd == n) return 1;
      if (nn == n) return 0;
      return 2;
   endfunction

   function automatic bit has_ill(input logic [33:0] w);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 17; i++) if (w[2*i +: 2] == 2'b11) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic [8:0] tok_sum(input logic [16:0] t);
      return 9'(t[16:9]) + 9'(t[8:1]) + 9'(t[0]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < STAGES; k++) begin
         mk[k] = 1'b0;
         mv[k] = '0;
      end
      merr = 1'b0;
   endtask

   task automatic model_step();
      bit          nk [STAGES];
      logic [16:0] nv [STAGES];
      bit          in_d, in_n, succ;
      logic [16:0] in_v;
      int          cls;
      cls = classify({cin, b, a}, 17);
      if (has_ill({cin, b, a})) merr = 1'b1;
      for (int k = 0; k < STAGES; k++) begin
         nk[k] = mk[k];
         nv[k] = mv[k];
         if (k == STAGES - 1) succ = out_comp;
         else                 succ = mk[k+1];
         if (k == 0) begin
            in_d = (cls == 1);
            in_n = (cls == 0);
            in_v = {dec8(a), dec8(b), cin[1]};
         end else begin
            in_d = mk[k-1];
            in_n = !mk[k-1];
            in_v = mv[k-1];
         end
         if (in_d && !succ) begin
            nk[k] = 1'b1;
            nv[k] = in_v;
         end else if (in_n && succ) begin
            nk[k] = 1'b0;
            nv[k] = '0;
         end
      end
      mk = nk;
      mv = nv;
   endtask

   task automatic compare_all();
      logic [8:0]  s;
      logic [15:0] es;
      logic [1:0]  ec;
      s  = tok_sum(mv[STAGES-1]);
      es = mk[STAGES-1] ? enc8(s[7:0]) : 16'h0;
      ec = mk[STAGES-1] ? (s[8] ? 2'b10 : 2'b01) : 2'b00;
      check("cyc_sum", 32'(sum), 32'(es));
      check("cyc_cout", 32'(cout), 32'(ec));
      check("cyc_in_comp", 32'(in_comp), 32'(mk[0]));
      check("cyc_err", 32'(err), 32'(merr));
   endtask

   task automatic drive_tok(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
      a   = enc8(ta);
      b   = enc8(tb);
      cin = tc ? 2'b10 : 2'b01;
   endtask

   task automatic drive_null();
      a   = '0;
      b   = '0;
      cin = '0;
   endtask

   task automatic source_step();
      if (src_ph == 1 && in_comp) begin
         exp_q.push_back(tok_sum(src_tok));
         acc_cnt++;
         drive_null();
         src_ph = 2;
      end else if (src_ph == 2 && !in_comp) begin
         src_ph = 0;
      end
      if (src_ph == 0 && src_q.size() > 0) begin
         src_tok = src_q.pop_front();
         drive_tok(src_tok[16:9], src_tok[8:1], src_tok[0]);
         src_ph = 1;
      end
   endtask

   task automatic sink_step();
      bit go;
      go = !snk_rand || ($urandom_range(0, 3) != 0);
      if (snk_hold || !go) return;
      if (!out_comp && classify({16'h0, cout, sum}, 9) == 1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sink_unexpected: got result %h with none outstanding", {cout, sum});
         end else begin
            check("sink_order", 32'({cout[1], dec8(sum)}), 32'(exp_q.pop_front()));
         end
         rx_cnt++;
         out_comp = 1'b1;
      end else if (out_comp && sum == 16'h0 && cout == 2'b00) begin
         out_comp = 1'b0;
      end
   endtask

   // One clock: model + compare just after the edge, then environment at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      compare_all();
      @(negedge clk);
      if (src_en) source_step();
      if (snk_en) sink_step();
   endtask

   task automatic flush();
      drive_null();
      out_comp = 1'b1;
      repeat (STAGES) tick();
      check("flush_sum", 32'(sum), 32'h0);
      check("flush_cout", 32'(cout), 32'h0);
      check("flush_in_comp", 32'(in_comp), 32'h0);
      out_comp = 1'b0;
   endtask

   task automatic wait_drain(input int n);
      int t;
      t = 0;
      while (rx_cnt < n && t < 3000) begin
         tick();
         t++;
      end
      check("drain_count", 32'(rx_cnt), 32'(n));
      check("drain_empty", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic push_rand(input int n);
      for (int i = 0; i < n; i++)
         src_q.push_back({8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1))});
   endtask

   initial begin
      logic [16:0] t;
      logic [8:0]  s;
      init = 1'b1;
      drive_null();
      out_comp = 1'b0;
      src_en = 0; snk_en = 0; snk_hold = 0; snk_rand = 0;
      src_ph = 0; acc_cnt = 0; rx_cnt = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_in_comp", 32'(in_comp), 32'h0);
      check("rst_sum", 32'(sum), 32'h0);
      check("rst_cout", 32'(cout), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      init = 1'b0;

      // Basic add: 0x5A + 0x3C = 0x96, four-cycle latency.
      drive_tok(8'h5A, 8'h3C, 1'b0);
      tick();
      check("basic_in_comp", 32'(in_comp), 32'h1);
      tick();
      tick();
      check("basic_not_early", 32'(sum), 32'h0);
      tick();
      check("basic_sum", 32'(sum), 32'h9669);
      check("basic_cout", 32'(cout), 32'h1);
      flush();

      // Overflow: 0xFF + 0x01 wraps to 0x00 with carry-out.
      drive_tok(8'hFF, 8'h01, 1'b0);
      repeat (STAGES) tick();
      check("ovf_sum", 32'(sum), 32'h5555);
      check("ovf_cout", 32'(cout), 32'h2);
      flush();

      // Partial input never captures.
      a   = enc8(8'h11);
      b   = '0;
      cin = 2'b01;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("partial_in_comp", 32'(in_comp), 32'h0);
         check("partial_sum", 32'(sum), 32'h0);
      end
      drive_null();
      tick();

      // Illegal pair for one cycle: sticky err, no capture, cleared only by init.
      drive_tok(8'h00, 8'h00, 1'b0);
      a[1:0] = 2'b11;
      tick();
      drive_null();
      check("ill_err", 32'(err), 32'h1);
      check("ill_no_capture", 32'(in_comp), 32'h0);
      repeat (5) tick();
      check("ill_sticky", 32'(err), 32'h1);
      #2 init = 1'b1;
      model_reset();
      #1 check("ill_cleared", 32'(err), 32'h0);
      @(negedge clk);
      init = 1'b0;

      // Backpressure: out_comp pinned high, only two tokens fit.
      out_comp = 1'b1;
      src_en = 1; snk_en = 1; snk_hold = 1; snk_rand = 0;
      acc_cnt = 0; rx_cnt = 0;
      push_rand(3);
      repeat (20) tick();
      check("bp_accepted", 32'(acc_cnt), 32'h2);
      check("bp_in_comp", 32'(in_comp), 32'h1);
      check("bp_sum_null", 32'(sum), 32'h0);
      snk_hold = 0;
      snk_rand = 1;
      wait_drain(3);

      // Reset with two tokens in flight, then a fresh operand.
      out_comp = 1'b1;
      snk_hold = 1;
      push_rand(3);
      repeat (12) tick();
      check("mid_in_flight", 32'(in_comp), 32'h1);
      #2 init = 1'b1;
      model_reset();
      src_en = 0; snk_en = 0; snk_hold = 0;
      src_q.delete();
      exp_q.delete();
      src_ph = 0;
      drive_null();
      out_comp = 1'b0;
      #1;
      check("mid_sum", 32'(sum), 32'h0);
      check("mid_cout", 32'(cout), 32'h0);
      check("mid_in_comp", 32'(in_comp), 32'h0);
      check("mid_err", 32'(err), 32'h0);
      @(negedge clk);
      init = 1'b0;
      t = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1};
      s = tok_sum(t);
      drive_tok(t[16:9], t[8:1], t[0]);
      repeat (STAGES) tick();
      check("post_rst_sum", 32'(sum), 32'(enc8(s[7:0])));
      check("post_rst_cout", 32'(cout), 32'(s[8] ? 2'b10 : 2'b01));
      flush();

      // Random stream with random downstream stalls, including corner operands.
      src_en = 1; snk_en = 1; snk_hold = 0; snk_rand = 1;
      rx_cnt = 0;
      src_q.push_back({8'h00, 8'h00, 1'b0});
      src_q.push_back({8'hFF, 8'hFF, 1'b1});
      push_rand(22);
      wait_drain(24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
